// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: control-transfer types,
// 2-bit counter states and the BTB index/tag width helpers.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BR_BRANCH = 2'b00,
        BR_JAL    = 2'b01,
        BR_JALR   = 2'b10,
        BR_RETURN = 2'b11
    } br_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Word-aligned PCs: bits [1:0] never take part in index or tag.
    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_width(input int entries);
        return 30 - $clog2(entries);
    endfunction

    function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
        return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predictor_return_stack.sv
// Non-speculative circular return-address stack; a push when full
// overwrites the oldest entry and a pop when empty is ignored.
module return_stack
    import branch_predictor_pkg::*;
#(
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(RAS_DEPTH);

    logic [31:0]   stack_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q;
    logic [PW:0]   count_q;
    logic [PW-1:0] top_ptr;
    logic          do_pop;

    assign top_ptr = ptr_q - 1'b1;
    assign top     = stack_q[top_ptr];
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;

    // Pop+push together replaces the top in place, so pointer and count hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push && !do_pop) begin
            ptr_q   <= ptr_q + 1'b1;
            count_q <= (count_q == FULL_COUNT) ? count_q : count_q + 1'b1;
        end else if (do_pop && !push) begin
            ptr_q   <= ptr_q - 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push && do_pop) begin
                stack_q[top_ptr] <= push_addr;
            end else if (push) begin
                stack_q[ptr_q] <= push_addr;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a return-address
// stack; zero-latency lookup, tables updated from resolved EX results.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    parameter int RAS_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_valid,
    input  logic [31:0] IF_pc,
    output logic        BTBhit,
    output logic [1:0]  IF_branch_prediction,
    output logic [1:0]  IF_type,
    output logic        predict_taken,
    output logic [31:0] IF_pc_imm,
    input  logic        EX_update,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_target,
    input  logic        EX_taken,
    input  logic [1:0]  EX_type,
    input  logic        EX_is_call
);

    localparam int IDX = idx_width(BTB_ENTRIES);
    localparam int TAG = tag_width(BTB_ENTRIES);

    logic            valid_q  [BTB_ENTRIES];
    logic [1:0]      ctr_q    [BTB_ENTRIES];
    logic [TAG-1:0]  tag_q    [BTB_ENTRIES];
    logic [31:0]     target_q [BTB_ENTRIES];
    br_type_e        type_q   [BTB_ENTRIES];

    logic [IDX-1:0]  if_idx;
    logic [TAG-1:0]  if_tag;
    logic [IDX-1:0]  ex_idx;
    logic [TAG-1:0]  ex_tag;
    br_type_e        ex_type;
    logic            ex_hit;
    logic            write_en;
    logic [31:0]     ras_top;
    logic            ras_empty;
    logic            unused_pc_bits;

    assign if_idx  = IF_pc[IDX+1:2];
    assign if_tag  = IF_pc[31:IDX+2];
    assign ex_idx  = EX_pc[IDX+1:2];
    assign ex_tag  = EX_pc[31:IDX+2];
    assign ex_type = br_type_e'(EX_type);
    assign unused_pc_bits = ^IF_pc[1:0];

    assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign write_en = EX_update && (ex_hit || EX_taken);

    // A not-taken miss leaves the tables alone; reset wins over any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (write_en) begin
            valid_q[ex_idx] <= 1'b1;
            if (ex_hit) begin
                ctr_q[ex_idx] <= EX_taken ? ctr_inc(ctr_q[ex_idx]) : ctr_dec(ctr_q[ex_idx]);
            end else begin
                ctr_q[ex_idx] <= (ex_type == BR_BRANCH) ? CTR_WT : CTR_ST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && write_en) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= EX_target;
            type_q[ex_idx]   <= ex_type;
        end
    end

    return_stack #(
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (EX_update && EX_is_call),
        .pop       (EX_update && (ex_type == BR_RETURN)),
        .push_addr (EX_pc + 32'd4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // Lookup sees only registered state, so same-cycle writes are not bypassed.
    always_comb begin
        BTBhit               = 1'b0;
        IF_branch_prediction = 2'b00;
        IF_type              = 2'b00;
        predict_taken        = 1'b0;
        IF_pc_imm            = 32'd0;
        if (IF_valid && !rst && valid_q[if_idx] && (tag_q[if_idx] == if_tag)) begin
            BTBhit               = 1'b1;
            IF_branch_prediction = ctr_q[if_idx];
            IF_type              = type_q[if_idx];
            predict_taken        = (type_q[if_idx] != BR_BRANCH) || ctr_q[if_idx][1];
            IF_pc_imm            = (type_q[if_idx] == BR_RETURN && !ras_empty) ?
                                   ras_top : target_q[if_idx];
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expected lookup results are queued
// as each lookup is driven and compared once the combinational output settles.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        IF_valid;
    logic [31:0] IF_pc;
    logic        BTBhit;
    logic [1:0]  IF_branch_prediction;
    logic [1:0]  IF_type;
    logic        predict_taken;
    logic [31:0] IF_pc_imm;
    logic        EX_update;
    logic [31:0] EX_pc;
    logic [31:0] EX_target;
    logic        EX_taken;
    logic [1:0]  EX_type;
    logic        EX_is_call;

    typedef struct {
        string       tag;
        logic        hit;
        logic [1:0]  ctr;
        logic [1:0]  typ;
        logic        taken;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    branch_predictor #(
        .BTB_ENTRIES(64),
        .RAS_DEPTH(8)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .IF_valid             (IF_valid),
        .IF_pc                (IF_pc),
        .BTBhit               (BTBhit),
        .IF_branch_prediction (IF_branch_prediction),
        .IF_type              (IF_type),
        .predict_taken        (predict_taken),
        .IF_pc_imm            (IF_pc_imm),
        .EX_update            (EX_update),
        .EX_pc                (EX_pc),
        .EX_target            (EX_target),
        .EX_taken             (EX_taken),
        .EX_type              (EX_type),
        .EX_is_call           (EX_is_call)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pushExpected(input string tag, input logic hit, input logic [1:0] ctr,
                                input logic [1:0] typ, input logic taken, input logic [31:0] imm);
        exp_t e;
        e.tag = tag; e.hit = hit; e.ctr = ctr; e.typ = typ; e.taken = taken; e.imm = imm;
        sb.push_back(e);
    endtask

    task automatic drainScoreboard();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.tag, ".hit"},   32'(BTBhit),               32'(e.hit));
            checkOutput({e.tag, ".ctr"},   32'(IF_branch_prediction), 32'(e.ctr));
            checkOutput({e.tag, ".type"},  32'(IF_type),              32'(e.typ));
            checkOutput({e.tag, ".taken"}, 32'(predict_taken),        32'(e.taken));
            checkOutput({e.tag, ".imm"},   IF_pc_imm,                 e.imm);
        end
    endtask

    // One resolved EX update, held across exactly one rising edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] target,
                                 input logic taken, input logic [1:0] typ, input logic is_call);
        @(negedge clk);
        EX_update = 1'b1; EX_pc = pc; EX_target = target;
        EX_taken = taken; EX_type = typ; EX_is_call = is_call;
        @(posedge clk);
        #1;
        EX_update = 1'b0; EX_is_call = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                          input logic [1:0] ctr, input logic [1:0] typ, input logic taken,
                          input logic [31:0] imm);
        @(negedge clk);
        IF_valid = 1'b1; IF_pc = pc;
        pushExpected(tag, hit, ctr, typ, taken, imm);
        #1;
        drainScoreboard();
    endtask

    task automatic lookupMiss(input string tag, input logic [31:0] pc);
        lookup(tag, pc, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; IF_valid = 1'b0; IF_pc = '0;
        EX_update = 1'b0; EX_pc = '0; EX_target = '0;
        EX_taken = 1'b0; EX_type = '0; EX_is_call = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] basic allocate and counter training");
        lookupMiss("reset_miss", 32'h100);
        applyStimulus(32'h100, 32'h200, 1'b1, 2'b00, 1'b0);
        lookup("alloc_br", 32'h100, 1'b1, 2'b10, 2'b00, 1'b1, 32'h200);

        @(negedge clk);
        IF_valid = 1'b0;
        pushExpected("if_invalid", 1'b0, 2'b00, 2'b00, 1'b0, 32'd0);
        #1 drainScoreboard();

        applyStimulus(32'h100, 32'h200, 1'b0, 2'b00, 1'b0);
        lookup("nt1", 32'h100, 1'b1, 2'b01, 2'b00, 1'b0, 32'h200);
        applyStimulus(32'h100, 32'h200, 1'b0, 2'b00, 1'b0);
        lookup("nt2", 32'h100, 1'b1, 2'b00, 2'b00, 1'b0, 32'h200);
        applyStimulus(32'h100, 32'h200, 1'b0, 2'b00, 1'b0);
        lookup("nt3_sat", 32'h100, 1'b1, 2'b00, 2'b00, 1'b0, 32'h200);
        applyStimulus(32'h100, 32'h200, 1'b1, 2'b00, 1'b0);
        lookup("t1", 32'h100, 1'b1, 2'b01, 2'b00, 1'b0, 32'h200);
        applyStimulus(32'h100, 32'h200, 1'b1, 2'b00, 1'b0);
        lookup("t2", 32'h100, 1'b1, 2'b10, 2'b00, 1'b1, 32'h200);
        applyStimulus(32'h100, 32'h200, 1'b1, 2'b00, 1'b0);
        applyStimulus(32'h100, 32'h200, 1'b1, 2'b00, 1'b0);
        lookup("t_sat", 32'h100, 1'b1, 2'b11, 2'b00, 1'b1, 32'h200);

        $display("[TB] aliasing and not-taken miss");
        applyStimulus(32'h200, 32'h280, 1'b1, 2'b01, 1'b0);
        lookupMiss("alias_old", 32'h100);
        lookup("alias_new", 32'h200, 1'b1, 2'b11, 2'b01, 1'b1, 32'h280);
        applyStimulus(32'h140, 32'h999, 1'b0, 2'b00, 1'b0);
        lookupMiss("nt_miss_nowrite", 32'h140);

        $display("[TB] same-cycle update and lookup");
        @(negedge clk);
        EX_update = 1'b1; EX_pc = 32'h200; EX_target = 32'h2C0;
        EX_taken = 1'b1; EX_type = 2'b10; EX_is_call = 1'b0;
        IF_valid = 1'b1; IF_pc = 32'h200;
        pushExpected("nobypass", 1'b1, 2'b11, 2'b01, 1'b1, 32'h280);
        #1 drainScoreboard();
        @(posedge clk);
        #1 EX_update = 1'b0;
        lookup("after_write", 32'h200, 1'b1, 2'b11, 2'b10, 1'b1, 32'h2C0);

        $display("[TB] reset overriding an update");
        @(negedge clk);
        rst = 1'b1;
        EX_update = 1'b1; EX_pc = 32'h300; EX_target = 32'h340;
        EX_taken = 1'b1; EX_type = 2'b01; EX_is_call = 1'b0;
        IF_valid = 1'b1; IF_pc = 32'h200;
        pushExpected("in_reset", 1'b0, 2'b00, 2'b00, 1'b0, 32'd0);
        #1 drainScoreboard();
        @(posedge clk);
        #1 rst = 1'b0; EX_update = 1'b0;
        lookupMiss("rst_cleared", 32'h200);
        lookupMiss("rst_nowrite", 32'h300);

        $display("[TB] return address stack");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(32'h1000 + 32'(4 * k), 32'h5000, 1'b1, 2'b01, 1'b1);
        end
        // Allocating the return entry pops once (top was 0x1024, now 0x1020).
        applyStimulus(32'h3000, 32'h3333, 1'b1, 2'b11, 1'b0);
        lookup("ret_after_pop", 32'h3000, 1'b1, 2'b11, 2'b11, 1'b1, 32'h1020);
        applyStimulus(32'h1020, 32'h5000, 1'b1, 2'b01, 1'b1);
        lookup("ret_full", 32'h3000, 1'b1, 2'b11, 2'b11, 1'b1, 32'h1024);
        for (int n = 1; n <= 7; n++) begin
            applyStimulus(32'h3000, 32'h3333, 1'b1, 2'b11, 1'b0);
            lookup($sformatf("ret_pop%0d", n), 32'h3000, 1'b1, 2'b11, 2'b11, 1'b1,
                   32'h1024 - 32'(4 * n));
        end
        applyStimulus(32'h3000, 32'h3333, 1'b1, 2'b11, 1'b0);
        lookup("ret_empty", 32'h3000, 1'b1, 2'b11, 2'b11, 1'b1, 32'h3333);
        applyStimulus(32'h3000, 32'h3333, 1'b1, 2'b11, 1'b0);
        lookup("ret_pop_empty", 32'h3000, 1'b1, 2'b11, 2'b11, 1'b1, 32'h3333);
        applyStimulus(32'h1040, 32'h5000, 1'b1, 2'b01, 1'b1);
        lookup("ret_push1", 32'h3000, 1'b1, 2'b11, 2'b11, 1'b1, 32'h1044);
        applyStimulus(32'h3000, 32'h3333, 1'b1, 2'b11, 1'b1);
        lookup("ret_poppush", 32'h3000, 1'b1, 2'b11, 2'b11, 1'b1, 32'h3004);
        applyStimulus(32'h3000, 32'h3333, 1'b1, 2'b11, 1'b0);
        lookup("ret_drained", 32'h3000, 1'b1, 2'b11, 2'b11, 1'b1, 32'h3333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
